// File: rtl/fetch_pipe_if.sv
// Instruction-memory request/response bus for fetch_pipe.
// The master (fetch stage) issues requests and accepts responses.
interface fetch_pipe_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic            imem_rsp_ready;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        output imem_rsp_ready,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        input  imem_rsp_ready,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_pipe.sv
// RV32I pipelined fetch stage: owns PCF, one outstanding imem request, IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_pipe #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int unsigned      CNT_WIDTH = 32
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      PCSrcE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic            StallD,
    fetch_pipe_if.master    imem,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_fetch_cnt,
    output logic [CNT_WIDTH-1:0] perf_stall_cnt,
    output logic [CNT_WIDTH-1:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pcf;
    logic [XLEN-1:0] w_pcf_nxt;
    logic [XLEN-1:0] w_pcf_plus4;
    logic [XLEN-1:0] w_target;
    logic            w_redirect;
    logic            w_accept;
    logic            w_req_valid;
    logic            w_rsp_ready;

    logic [31:0]     r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pc4_d;
    logic            r_valid_d;

    assign w_redirect  = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
    assign w_pcf_plus4 = r_pcf + XLEN'(4);
    // JALR target has bit 0 forced low; masking keeps every ALUResultE bit in use.
    assign w_target    = (PCSrcE == 2'b10) ? (ALUResultE & ~{{(XLEN-1){1'b0}}, 1'b1})
                                           : (PCE + ImmExtE);

    always_comb begin
        w_state_nxt = r_state;
        w_pcf_nxt   = r_pcf;
        w_req_valid = 1'b0;
        w_rsp_ready = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_req_valid = !w_redirect;
                if (w_redirect) begin
                    w_pcf_nxt = w_target;
                end else if (imem.imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_rsp_ready = !(r_valid_d && StallD) || w_redirect;
                if (w_redirect) begin
                    w_pcf_nxt   = w_target;
                    w_state_nxt = imem.imem_rsp_valid ? S_FETCH : S_DISCARD;
                end else if (imem.imem_rsp_valid && w_rsp_ready) begin
                    w_accept    = 1'b1;
                    w_pcf_nxt   = w_pcf_plus4;
                    w_state_nxt = S_FETCH;
                end
            end
            S_DISCARD: begin
                w_rsp_ready = 1'b1;
                if (w_redirect) begin
                    w_pcf_nxt = w_target;
                end
                // A stale response landing alongside a redirect is still the one we owe.
                if (imem.imem_rsp_valid) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pcf   <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pcf   <= w_pcf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_d <= 1'b0;
            r_instr_d <= NOP_INSTR;
            r_pc_d    <= '0;
            r_pc4_d   <= '0;
        end else if (w_redirect) begin
            r_valid_d <= 1'b0;
            r_instr_d <= NOP_INSTR;
        end else if (w_accept) begin
            r_valid_d <= 1'b1;
            r_instr_d <= imem.imem_rsp_data;
            r_pc_d    <= r_pcf;
            r_pc4_d   <= w_pcf_plus4;
        end else if (!(r_valid_d && StallD)) begin
            r_valid_d <= 1'b0;
            r_instr_d <= NOP_INSTR;
        end
    end

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_addr      = r_pcf;
    assign imem.imem_rsp_ready = w_rsp_ready;
    assign InstrD              = r_instr_d;
    assign PCD                 = r_pc_d;
    assign PCPlus4D            = r_pc4_d;
    assign ValidD              = r_valid_d;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_fetch_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_accept && !w_redirect) begin
                r_fetch_cnt <= r_fetch_cnt + CNT_WIDTH'(1);
            end
            if (r_valid_d && StallD) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
            if (w_redirect) begin
                r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_pipe.sv
// Directed table-driven bench for fetch_pipe; the bench plays the instruction memory
// cycle by cycle, so every row fixes memory behaviour and the expected stage outputs.
module tb_fetch_pipe;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  PCSrcE;
    logic [31:0] PCE;
    logic [31:0] ImmExtE;
    logic [31:0] ALUResultE;
    logic        StallD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    fetch_pipe_if #(.XLEN(32)) imem ();

    fetch_pipe #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCSrcE     (PCSrcE),
        .PCE        (PCE),
        .ImmExtE    (ImmExtE),
        .ALUResultE (ALUResultE),
        .StallD     (StallD),
        .imem       (imem),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] pce;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        stall;
        logic        rq_rdy;
        logic        rs_vld;
        logic [31:0] rs_data;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_rsr;
        logic        e_vd;
        logic [31:0] e_instr;
        logic [31:0] e_pcd;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t        tbl[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    function automatic vec_t mk(
        input logic [1:0] src, input logic [31:0] pce, input logic [31:0] imm, input logic [31:0] alu,
        input logic stall, input logic rq_rdy, input logic rs_vld, input logic [31:0] rs_data,
        input logic e_rqv, input logic [31:0] e_addr, input logic e_rsr, input logic e_vd,
        input logic [31:0] e_instr, input logic [31:0] e_pcd, input logic [31:0] e_pc4);
        vec_t v;
        v.src = src; v.pce = pce; v.imm = imm; v.alu = alu;
        v.stall = stall; v.rq_rdy = rq_rdy; v.rs_vld = rs_vld; v.rs_data = rs_data;
        v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_rsr = e_rsr; v.e_vd = e_vd;
        v.e_instr = e_instr; v.e_pcd = e_pcd; v.e_pc4 = e_pc4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one cycle's inputs at the falling edge, then compare 1 time unit later.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst                 = 1'b0;
        PCSrcE              = v.src;
        PCE                 = v.pce;
        ImmExtE             = v.imm;
        ALUResultE          = v.alu;
        StallD              = v.stall;
        imem.imem_req_ready = v.rq_rdy;
        imem.imem_rsp_valid = v.rs_vld;
        imem.imem_rsp_data  = v.rs_data;
        #1;
        chk({tag, ".req_valid"}, 32'(imem.imem_req_valid), 32'(v.e_rqv));
        chk({tag, ".addr"},      imem.imem_addr,           v.e_addr);
        chk({tag, ".rsp_ready"}, 32'(imem.imem_rsp_ready), 32'(v.e_rsr));
        chk({tag, ".ValidD"},    32'(ValidD),              32'(v.e_vd));
        chk({tag, ".InstrD"},    InstrD,                   v.e_instr);
        chk({tag, ".PCD"},       PCD,                      v.e_pcd);
        chk({tag, ".PCPlus4D"},  PCPlus4D,                 v.e_pc4);
    endtask

    initial begin
        rst = 1'b1; PCSrcE = 2'b00; PCE = '0; ImmExtE = '0; ALUResultE = '0; StallD = 1'b0;
        imem.imem_req_ready = 1'b0; imem.imem_rsp_valid = 1'b0; imem.imem_rsp_data = '0;

        //          src  pce     imm          alu     st rr rv data           rqv addr          rsr vd instr          pcd           pc4
        // basic flow with 1-cycle memory (row 0 doubles as reset-state check)
        tbl.push_back(mk(0, 0,     0,           0,      0, 1, 0, 0,            1, 32'h0,        0, 0, NOP,           32'h0,        32'h0));
        tbl.push_back(mk(0, 0,     0,           0,      0, 0, 1, 32'h00500093, 0, 32'h0,        1, 0, NOP,           32'h0,        32'h0));
        // decode stalls while response for 0x4 is pending
        tbl.push_back(mk(0, 0,     0,           0,      1, 1, 0, 0,            1, 32'h4,        0, 1, 32'h00500093,  32'h0,        32'h4));
        tbl.push_back(mk(0, 0,     0,           0,      1, 0, 1, 32'h00100113, 0, 32'h4,        0, 1, 32'h00500093,  32'h0,        32'h4));
        tbl.push_back(mk(0, 0,     0,           0,      1, 0, 1, 32'h00100113, 0, 32'h4,        0, 1, 32'h00500093,  32'h0,        32'h4));
        tbl.push_back(mk(0, 0,     0,           0,      1, 0, 1, 32'h00100113, 0, 32'h4,        0, 1, 32'h00500093,  32'h0,        32'h4));
        tbl.push_back(mk(0, 0,     0,           0,      0, 0, 1, 32'h00100113, 0, 32'h4,        1, 1, 32'h00500093,  32'h0,        32'h4));
        tbl.push_back(mk(0, 0,     0,           0,      0, 1, 0, 0,            1, 32'h8,        0, 1, 32'h00100113,  32'h4,        32'h8));
        // branch redirect in WAIT, latency 3 -> DISCARD, stale response dropped
        tbl.push_back(mk(1, 32'h10, 32'hFFFFFFF8, 0,    0, 0, 0, 0,            0, 32'h8,        1, 0, NOP,           32'h4,        32'h8));
        tbl.push_back(mk(0, 0,     0,           0,      0, 0, 0, 0,            0, 32'h8,        1, 0, NOP,           32'h4,        32'h8));
        tbl.push_back(mk(0, 0,     0,           0,      0, 0, 1, 32'hDEADBEEF, 0, 32'h8,        1, 0, NOP,           32'h4,        32'h8));
        tbl.push_back(mk(0, 0,     0,           0,      0, 1, 0, 0,            1, 32'h8,        0, 0, NOP,           32'h4,        32'h8));
        tbl.push_back(mk(0, 0,     0,           0,      0, 0, 1, 32'h00208193, 0, 32'h8,        1, 0, NOP,           32'h4,        32'h8));
        // JALR redirect in FETCH: no request that cycle, next at 0x100
        tbl.push_back(mk(2, 0,     0,           32'h101, 0, 1, 0, 0,           0, 32'hC,        0, 1, 32'h00208193,  32'h8,        32'hC));
        tbl.push_back(mk(0, 0,     0,           0,      0, 1, 0, 0,            1, 32'h100,      0, 0, NOP,           32'h8,        32'hC));
        // redirect coincident with response in WAIT -> dropped, straight to FETCH
        tbl.push_back(mk(1, 32'h200, 32'h20,    0,      0, 0, 1, 32'h00300193, 0, 32'h100,      1, 0, NOP,           32'h8,        32'hC));
        tbl.push_back(mk(0, 0,     0,           0,      0, 0, 0, 0,            1, 32'h220,      0, 0, NOP,           32'h8,        32'hC));
        tbl.push_back(mk(0, 0,     0,           0,      0, 1, 0, 0,            1, 32'h220,      0, 0, NOP,           32'h8,        32'hC));
        // StallD with empty IF/ID still accepts
        tbl.push_back(mk(0, 0,     0,           0,      1, 0, 1, 32'h00400213, 0, 32'h220,      1, 0, NOP,           32'h8,        32'hC));
        // flush beats stall; redirect to top of address space
        tbl.push_back(mk(1, 0,     32'hFFFFFFFC, 0,     1, 1, 0, 0,            0, 32'h224,      0, 1, 32'h00400213,  32'h220,      32'h224));
        tbl.push_back(mk(0, 0,     0,           0,      0, 1, 0, 0,            1, 32'hFFFFFFFC, 0, 0, NOP,           32'h220,      32'h224));
        tbl.push_back(mk(0, 0,     0,           0,      0, 0, 1, 32'h00500293, 0, 32'hFFFFFFFC, 1, 0, NOP,           32'h220,      32'h224));
        // PCF wraps to 0
        tbl.push_back(mk(0, 0,     0,           0,      0, 0, 0, 0,            1, 32'h0,        0, 1, 32'h00500293,  32'hFFFFFFFC, 32'h0));
        tbl.push_back(mk(0, 0,     0,           0,      0, 1, 0, 0,            1, 32'h0,        0, 0, NOP,           32'hFFFFFFFC, 32'h0));
        // redirect in WAIT, then again in DISCARD: last target wins
        tbl.push_back(mk(1, 32'h40, 32'h4,      0,      0, 0, 0, 0,            0, 32'h0,        1, 0, NOP,           32'hFFFFFFFC, 32'h0));
        tbl.push_back(mk(2, 0,     0,           32'h81, 0, 0, 0, 0,            0, 32'h44,       1, 0, NOP,           32'hFFFFFFFC, 32'h0));
        tbl.push_back(mk(0, 0,     0,           0,      0, 0, 1, 32'h0BADF00D, 0, 32'h80,       1, 0, NOP,           32'hFFFFFFFC, 32'h0));
        tbl.push_back(mk(0, 0,     0,           0,      0, 1, 0, 0,            1, 32'h80,       0, 0, NOP,           32'hFFFFFFFC, 32'h0));
        tbl.push_back(mk(0, 0,     0,           0,      0, 0, 1, 32'h00600313, 0, 32'h80,       1, 0, NOP,           32'hFFFFFFFC, 32'h0));
        tbl.push_back(mk(0, 0,     0,           0,      0, 1, 0, 0,            1, 32'h84,       0, 1, 32'h00600313,  32'h80,       32'h84));

        repeat (2) @(posedge clk);
        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // reset while a request for 0x84 is outstanding
        @(negedge clk);
        rst = 1'b1;
        PCSrcE = 2'b00; StallD = 1'b0;
        imem.imem_req_ready = 1'b0; imem.imem_rsp_valid = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, NOP, 32'h0, 32'h0), "rst_wait");
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_rst", perf_fetch_cnt, 32'h0);
        chk("perf_stall_rst", perf_stall_cnt, 32'h0);
        chk("perf_flush_rst", perf_flush_cnt, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_pipe.md
Name: fetch_pipe

Overview:
Pipelined instruction-fetch stage for the RV32I core, generalised from the single-cycle fetch path.
- Owns PCF and issues instruction-memory requests over a valid/ready request/response handshake that tolerates variable latency.
- Drives the IF/ID pipeline register to decode.
- Supports decode stall and execute-stage redirect (branch, JAL, JALR), including squashing of in-flight fetches.

Parameters:
XLEN, 32, datapath/PC width in bits
RESET_PC, 32'h0000_0000, PCF value after reset
NOP_INSTR, 32'h0000_0013, instruction placed in InstrD when the stage is empty (addi x0,x0,0)
CNT_WIDTH, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
PCSrcE  in  2  redirect select from execute: 00 none, 01 PCE+ImmExtE, 10 ALUResultE with bit0 cleared, 11 treated as 00
PCE  in  XLEN  PC of instruction in execute
ImmExtE  in  XLEN  extended immediate from execute
ALUResultE  in  XLEN  JALR target from execute
StallD  in  1  decode cannot accept a new instruction
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  XLEN  request address, equals PCF
imem_rsp_valid  in  1  response valid (held until accepted)
imem_rsp_ready  out  1  stage accepts response
imem_rsp_data  in  32  fetched instruction
InstrD  out  32  IF/ID instruction
PCD  out  XLEN  IF/ID PC
PCPlus4D  out  XLEN  IF/ID PC+4
ValidD  out  1  IF/ID holds a live instruction

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: PCF=RESET_PC; state=FETCH; ValidD=0; InstrD=NOP_INSTR; PCD=0; PCPlus4D=0.
- Reset mid-operation abandons any outstanding request. Memory shares rst, so no response is expected afterwards.
- redirect = (PCSrcE==01 || PCSrcE==10).
- Target calculation: PCE+ImmExtE for 01, or {ALUResultE[XLEN-1:1],1'b0} for 10. All adds are modulo 2^XLEN.
- No misalignment trap. imem_addr passes PCF unmodified.
- FSM states: FETCH, WAIT, DISCARD. At most one request outstanding.
- FETCH:
  - imem_req_valid = !redirect. imem_rsp_ready = 0.
  - redirect: PCF<=target, stay FETCH.
  - else if imem_req_ready: go to WAIT.
- WAIT:
  - imem_req_valid = 0. imem_rsp_ready = !(ValidD && StallD) || redirect.
  - redirect, with or without a response this cycle: PCF<=target. If imem_rsp_valid, drop the response and go to FETCH; else go to DISCARD.
  - otherwise, on a response handshake: InstrD<=imem_rsp_data, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1, PCF<=PCF+4, go to FETCH.
  - Response arriving while decode is stalled with ValidD=1 is not accepted. Memory holds it until ready.
- DISCARD:
  - imem_req_valid = 0. imem_rsp_ready = 1.
  - On imem_rsp_valid: drop the response, go to FETCH.
  - Redirect in DISCARD: PCF<=new target, stay DISCARD.
- IF/ID register:
  - redirect flushes: ValidD<=0, InstrD<=NOP_INSTR, same cycle. Flush has priority over StallD.
  - If StallD=1 with ValidD=1, hold all IF/ID outputs.
  - If decode consumes (StallD=0) and no new response arrives, ValidD<=0 and InstrD<=NOP_INSTR.
- Throughput: 1 instruction per 2 cycles minimum, with a 1-cycle-latency memory (request cycle, response cycle).
- Redirect penalty: the request for the target issues the cycle after the redirect.
- PCF wrap-around: 0xFFFF_FFFC+4 = 0x0000_0000, no flag.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt, each CNT_WIDTH bits, reset to 0.
  - perf_fetch_cnt increments per response written to IF/ID.
  - perf_stall_cnt increments per cycle with ValidD&&StallD.
  - perf_flush_cnt increments per redirect cycle.
  - All counters wrap silently.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, 1-cycle memory returning 0x00500093 at 0x0 and 0x00100113 at 0x4, StallD=0 -> imem_addr 0x0,0x4,0x8 in order; PCD=0x0 with InstrD=0x00500093, then PCD=0x4 with PCPlus4D=0x8; ValidD pulses.
- StallD=1 for 3 cycles while ValidD=1 and response for 0x4 is pending -> imem_rsp_ready=0, IF/ID unchanged, response accepted the cycle StallD drops.
- Redirect PCSrcE=01, PCE=0x10, ImmExtE=0xFFFFFFF8 while in WAIT with memory latency 3 -> DISCARD entered, stale response dropped, next imem_addr=0x8, ValidD=0 that cycle.
- PCSrcE=10, ALUResultE=0x101 in FETCH -> imem_req_valid=0 that cycle, next request imem_addr=0x100.
- Redirect coincident with imem_rsp_valid in WAIT -> response dropped (ValidD=0), state FETCH, no DISCARD.
- rst asserted in WAIT -> next cycle PCF=RESET_PC, ValidD=0, InstrD=0x00000013. With FETCH_PERF_CNT_EN defined, all counters read 0.
